sni_host: RTL and testbench

Host-side initiator for the Super Nintendo Interface UART link. It accepts one command at a time from a local requester: PING, READ, WRITE or WAITNMI. It serializes the command bytes onto the UART transmit handshake, parses the responder's length byte and any read data, and reports completion or error. It sits between a debug/test master and the MiSTer UART core, and talks to an SNI responder at the far end.

---
 rtl/sni_host.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_sni_host.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sni_host.sv
// Host-side initiator for the SNI UART link: serializes PING/READ/WRITE/WAITNMI
// commands onto the UART transmit handshake and parses the responder's reply.
module sni_host #(
    parameter logic [23:0] TIMEOUT = 24'd4_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        rbf,
    input  logic        txint,
    input  logic        rxint,
    output logic        tdata_i,
    output logic [15:0] tdata_m,
    input  logic [15:0] rdata_m
);

    localparam int unsigned FIFO_AW    = 4;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned TMO_W      = 24;

    // Each TX_* state means "that byte is in flight"; the next byte launches on tx_free.
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_TX_CMD   = 4'd1;
    localparam logic [3:0] S_TX_A0    = 4'd2;
    localparam logic [3:0] S_TX_A1    = 4'd3;
    localparam logic [3:0] S_TX_A2    = 4'd4;
    localparam logic [3:0] S_TX_LEN   = 4'd5;
    localparam logic [3:0] S_TX_PING  = 4'd6;
    localparam logic [3:0] S_TX_WDATA = 4'd7;
    localparam logic [3:0] S_RX_LEN   = 4'd8;
    localparam logic [3:0] S_RX_DATA  = 4'd9;

    localparam logic [1:0] OP_PING  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    logic [3:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [23:0]        addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               tinprog_q, tinprog_d;
    logic               last_txint_q, last_rxint_q;
    logic [FIFO_AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [7:0]         fifo_q [FIFO_DEPTH];

    logic               tdata_i_q, tdata_i_d;
    logic [15:0]        tdata_m_q, tdata_m_d;
    logic               wr_ready_q, wr_ready_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               rbf_q, rbf_d;
    logic               cmd_ready_q, cmd_ready_d;

    logic               tx_fall, rx_fall, tx_free;
    logic               fifo_empty, fifo_full, push, pop;
    logic [FIFO_AW-1:0] raddr_m1, raddr_d_m1;
    logic [7:0]         fifo_rd;
    logic [7:0]         exp_len;
    logic               launch;
    logic [7:0]         tx_byte;
    logic               unused_rdata_hi;

    assign unused_rdata_hi = ^rdata_m[15:8];

    assign tx_fall    = last_txint_q & ~txint;
    assign rx_fall    = last_rxint_q & ~rxint;
    assign tx_free    = ~tinprog_q | tx_fall;
    assign raddr_m1   = raddr_q - FIFO_AW'(1);
    assign fifo_empty = (waddr_q == raddr_q);
    assign fifo_full  = (waddr_q == raddr_m1);
    assign push       = rx_fall & ~fifo_full;
    assign fifo_rd    = fifo_q[raddr_q];

    // Length byte the responder must return for the latched command.
    always_comb begin
        exp_len = 8'd0;
        case (op_q)
            OP_PING: exp_len = 8'd1;
            OP_READ: exp_len = len_q;
            default: exp_len = 8'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        pop        = 1'b0;
        launch     = 1'b0;
        tx_byte    = 8'h00;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                pop = ~fifo_empty;
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    launch  = 1'b1;
                    tx_byte = {6'd0, cmd_op};
                    state_d = S_TX_CMD;
                end
            end
            S_TX_CMD: begin
                if (tx_free) begin
                    case (op_q)
                        OP_PING: begin
                            launch  = 1'b1;
                            tx_byte = len_q;
                            state_d = S_TX_PING;
                        end
                        OP_READ, OP_WRITE: begin
                            launch  = 1'b1;
                            tx_byte = addr_q[7:0];
                            state_d = S_TX_A0;
                        end
                        default: state_d = S_RX_LEN;
                    endcase
                end
            end
            S_TX_A0: begin
                if (tx_free) begin
                    launch  = 1'b1;
                    tx_byte = addr_q[15:8];
                    state_d = S_TX_A1;
                end
            end
            S_TX_A1: begin
                if (tx_free) begin
                    launch  = 1'b1;
                    tx_byte = addr_q[23:16];
                    state_d = S_TX_A2;
                end
            end
            S_TX_A2: begin
                if (tx_free) begin
                    launch  = 1'b1;
                    tx_byte = len_q;
                    state_d = S_TX_LEN;
                end
            end
            S_TX_LEN: begin
                if (tx_free) begin
                    if (op_q == OP_WRITE && len_q != 8'd0) begin
                        // Launch the first payload byte right away when it is ready.
                        if (wr_valid) begin
                            launch     = 1'b1;
                            tx_byte    = wr_data;
                            wr_ready_d = 1'b1;
                            cnt_d      = len_q - 8'd1;
                        end else begin
                            cnt_d = len_q;
                        end
                        state_d = S_TX_WDATA;
                    end else begin
                        state_d = S_RX_LEN;
                    end
                end
            end
            S_TX_WDATA: begin
                if (cnt_q != 8'd0) begin
                    if (tx_free && wr_valid) begin
                        launch     = 1'b1;
                        tx_byte    = wr_data;
                        wr_ready_d = 1'b1;
                        cnt_d      = cnt_q - 8'd1;
                    end
                end else if (tx_free) begin
                    state_d = S_RX_LEN;
                end
            end
            S_TX_PING: begin
                if (tx_free) state_d = S_RX_LEN;
            end
            S_RX_LEN: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (fifo_rd != exp_len) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (exp_len == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = exp_len;
                        state_d = S_RX_DATA;
                    end
                end else if (TIMEOUT != '0 && tmo_q == TIMEOUT - TMO_W'(1)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_RX_DATA: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    rd_data_d  = fifo_rd;
                    rd_valid_d = 1'b1;
                    cnt_d      = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (TIMEOUT != '0 && tmo_q == TIMEOUT - TMO_W'(1)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tdata_i_d   = launch;
        tdata_m_d   = launch ? {8'h01, tx_byte} : tdata_m_q;
        tinprog_d   = launch ? 1'b1 : (tx_fall ? 1'b0 : tinprog_q);
        waddr_d     = waddr_q + FIFO_AW'(push);
        raddr_d     = raddr_q + FIFO_AW'(pop);
        raddr_d_m1  = raddr_d - FIFO_AW'(1);
        rbf_d       = (waddr_d == raddr_d_m1);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 2'd0;
            addr_q       <= 24'd0;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            tmo_q        <= '0;
            tinprog_q    <= 1'b0;
            last_txint_q <= 1'b0;
            last_rxint_q <= 1'b0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            tdata_i_q    <= 1'b0;
            tdata_m_q    <= 16'h0100;
            wr_ready_q   <= 1'b0;
            rd_data_q    <= 8'd0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rbf_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            tinprog_q    <= tinprog_d;
            last_txint_q <= txint;
            last_rxint_q <= rxint;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            tdata_i_q    <= tdata_i_d;
            tdata_m_q    <= tdata_m_d;
            wr_ready_q   <= wr_ready_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rbf_q        <= rbf_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    // Bytes arriving while full are dropped by gating push.
    always_ff @(posedge clk) begin
        if (push) fifo_q[waddr_q] <= rdata_m[7:0];
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rbf       = rbf_q;
    assign tdata_i   = tdata_i_q;
    assign tdata_m   = tdata_m_q;

endmodule

// File: tb/tb_sni_host.sv
// Directed bench for sni_host with a small UART transmit model folded into tick().
module tb_sni_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        rbf;
    logic        txint;
    logic        rxint;
    logic        tdata_i;
    logic [15:0] tdata_m;
    logic [15:0] rdata_m;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] txq[$];
    logic [7:0] rdq[$];
    logic [7:0] wdq[$];
    int   wr_idx, wr_cnt, wr_bad, hdr_bad;
    int   done_cnt, done_cyc, fall_cyc, followups, tx_hold;
    logic last_err;
    bit   tx_auto, just_fell;

    sni_host #(.TIMEOUT(24'd100)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .rbf(rbf), .txint(txint), .rxint(rxint),
        .tdata_i(tdata_i), .tdata_m(tdata_m), .rdata_m(rdata_m)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp_q[$]);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
    endtask

    // One clock; sample outputs, then run the UART transmit model and payload supplier.
    task automatic tick();
        @(posedge clk);
        #1;
        if (tdata_i) begin
            txq.push_back(tdata_m[7:0]);
            if (tdata_m[15:8] !== 8'h01) hdr_bad++;
        end
        if (rd_valid) rdq.push_back(rd_data);
        if (done) begin
            done_cnt++;
            last_err = err;
            done_cyc = cyc;
        end
        if (wr_ready) begin
            wr_cnt++;
            if (!tdata_i || wr_idx >= wdq.size() || tdata_m[7:0] !== wdq[wr_idx]) wr_bad++;
            wr_idx++;
            if (wr_idx < wdq.size()) wr_data = wdq[wr_idx];
            else wr_valid = 1'b0;
        end
        if (just_fell && tdata_i) followups++;
        just_fell = 1'b0;
        if (tx_auto) begin
            if (tx_hold > 0) begin
                tx_hold--;
                if (tx_hold == 0) begin
                    txint     = 1'b0;
                    fall_cyc  = cyc;
                    just_fell = 1'b1;
                end
            end else if (tdata_i) begin
                txint   = 1'b1;
                tx_hold = 3;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic inject(input logic [7:0] b);
        rdata_m = {8'hFF, b};
        rxint   = 1'b1;
        tick();
        rxint   = 1'b0;
        tick();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len);
        check("cmd_ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        check("first_tx_latency", {tdata_i, tdata_m}, {1'b1, 8'h01, 6'd0, op});
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (txq.size() < n && k < 2000) begin
            tick();
            k++;
        end
        check("wait_tx_bound", txq.size() >= n, 1);
    endtask

    task automatic wait_done(input int start);
        int k = 0;
        while (done_cnt == start && k < 2000) begin
            tick();
            k++;
        end
        check("wait_done_bound", done_cnt, start + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tdata_i"}, tdata_i, 0);
        check({tag, "_tdata_m"}, tdata_m, 16'h0100);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rbf"}, rbf, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
    endtask

    task automatic clear_logs();
        txq.delete();
        rdq.delete();
        followups = 0;
    endtask

    initial begin
        logic [7:0] e[$];
        int d0;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 24'd0; cmd_len = 8'd0;
        wr_data = 8'd0; wr_valid = 1'b0; txint = 1'b0; rxint = 1'b0; rdata_m = 16'd0;
        wr_idx = 0; wr_cnt = 0; wr_bad = 0; hdr_bad = 0; done_cnt = 0; done_cyc = 0;
        fall_cyc = 0; followups = 0; tx_hold = 0; last_err = 1'b0;
        tx_auto = 1'b1; just_fell = 1'b0;

        ticks(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        check("cmd_ready_after_reset", cmd_ready, 1);

        // PING 0x5A
        clear_logs(); d0 = done_cnt;
        send_cmd(2'd0, 24'd0, 8'h5A);
        wait_tx(2);
        inject(8'h01); inject(8'h5A);
        wait_done(d0); ticks(3);
        e = '{8'h00, 8'h5A}; check_bytes("ping_tx", txq, e);
        e = '{8'h5A};        check_bytes("ping_rd", rdq, e);
        check("ping_err", last_err, 0);
        check("ping_tx_gap", followups, 1);
        check("ping_done_once", done_cnt, d0 + 1);

        // READ F5_1234 len 3
        clear_logs(); d0 = done_cnt;
        send_cmd(2'd1, 24'hF51234, 8'd3);
        wait_tx(5);
        inject(8'h03); inject(8'hAA); inject(8'hBB); inject(8'hCC);
        wait_done(d0); ticks(3);
        e = '{8'h01, 8'h34, 8'h12, 8'hF5, 8'h03}; check_bytes("read_tx", txq, e);
        e = '{8'hAA, 8'hBB, 8'hCC};               check_bytes("read_rd", rdq, e);
        check("read_err", last_err, 0);
        check("read_tx_gap", followups, 4);

        // WRITE F6_0000 len 2, response buffered while payload still pending
        clear_logs(); d0 = done_cnt;
        wdq = '{8'h11, 8'h22}; wr_idx = 0; wr_cnt = 0; wr_bad = 0;
        wr_data = 8'h11; wr_valid = 1'b1;
        send_cmd(2'd2, 24'hF60000, 8'd2);
        wait_tx(5);
        inject(8'h00);
        wait_done(d0); ticks(3);
        e = '{8'h02, 8'h00, 8'h00, 8'hF6, 8'h02, 8'h11, 8'h22}; check_bytes("write_tx", txq, e);
        check("write_wr_ready_count", wr_cnt, 2);
        check("write_wr_ready_align", wr_bad, 0);
        check("write_tx_gap", followups, 6);
        check("write_err", last_err, 0);
        check("write_no_rd", rdq.size(), 0);

        // READ len 2 with wrong length byte
        clear_logs(); d0 = done_cnt;
        send_cmd(2'd1, 24'h000010, 8'd2);
        wait_tx(5);
        ticks(6);
        inject(8'h05);
        check("mismatch_done_pop_cycle", done, 0);
        tick();
        check("mismatch_done", done, 1);
        check("mismatch_err", err, 1);
        ticks(3);
        check("mismatch_no_rd", rdq.size(), 0);
        check("mismatch_done_once", done_cnt, d0 + 1);

        // WAITNMI timeout, then a late byte flushed in IDLE
        clear_logs(); d0 = done_cnt;
        send_cmd(2'd3, 24'd0, 8'd0);
        wait_done(d0);
        check("timeout_err", last_err, 1);
        check("timeout_latency", done_cyc - fall_cyc, 101);
        e = '{8'h03}; check_bytes("waitnmi_tx", txq, e);
        d0 = done_cnt;
        inject(8'h00);
        ticks(10);
        check("late_byte_no_done", done_cnt, d0);

        clear_logs(); d0 = done_cnt;
        send_cmd(2'd0, 24'd0, 8'h33);
        wait_tx(2);
        inject(8'h01); inject(8'h33);
        wait_done(d0); ticks(3);
        e = '{8'h33}; check_bytes("ping2_rd", rdq, e);
        check("ping2_err", last_err, 0);

        // FIFO fill while transmit is stalled: full at 15, extras dropped
        clear_logs(); d0 = done_cnt;
        tx_auto = 1'b0;
        send_cmd(2'd1, 24'd0, 8'd14);
        inject(8'h0E);
        for (int i = 0; i < 13; i++) inject(8'hC0 + 8'(i));
        check("rbf_at_14", rbf, 0);
        inject(8'hCD);
        check("rbf_at_15", rbf, 1);
        inject(8'hEE); inject(8'hEF);
        check("rbf_after_drop", rbf, 1);
        txint = 1'b1;
        tick();
        txint = 1'b0;
        tx_auto = 1'b1;
        wait_done(d0); ticks(3);
        e = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0E}; check_bytes("full_tx", txq, e);
        e.delete();
        for (int i = 0; i < 14; i++) e.push_back(8'hC0 + 8'(i));
        check_bytes("full_rd", rdq, e);
        check("full_err", last_err, 0);
        check("rbf_drained", rbf, 0);

        // Reset in the middle of a READ
        clear_logs(); d0 = done_cnt;
        send_cmd(2'd1, 24'h0000A5, 8'd1);
        wait_tx(2);
        reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b0;
        tick();
        check("cmd_ready_after_midreset", cmd_ready, 1);
        ticks(10);
        check("midreset_no_done", done_cnt, d0);
        check("midreset_no_more_tx", txq.size(), 2);
        check("tx_header_byte", hdr_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
